// File: rtl/g07_slave_mem_pkg.sv
// Shared types and address-field constants for the g07 bus slave responder.
// Pure definitions; no timing or flow control of its own.
package g07_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2,
    HOLD      = 2'd3
  } slv_state_t;

  localparam int WR_BIT = 63;
  localparam int SEL_HI = 62;
  localparam int SEL_LO = 60;
  localparam int OFS_W  = 3;

  localparam logic [63:0] ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

  // Misaligned byte offset, or any address bit above the word index but below the select field.
  function automatic logic addr_err(input logic [63:0] a, input int iw);
    logic e;
    e = 1'b0;
    for (int b = 0; b < SEL_LO; b++) begin
      if (b < OFS_W || b >= iw + OFS_W) e = e | a[b];
    end
    return e;
  endfunction

endpackage

// File: rtl/g07_slave_mem_if.sv
// Arbiter-to-slave port bundle: address/data/enable/done from the arbiter, read data back.
// No flow control beyond en/Tdone; the slave holds dbus_out until Tdone.
interface g07_slave_mem_if;
  logic [63:0] addr;
  logic [63:0] SbusIn;
  logic        en;
  logic        Tdone;
  logic [63:0] dbus_out;

  modport master (output addr, output SbusIn, output en, output Tdone, input dbus_out);
  modport slave  (input addr, input SbusIn, input en, input Tdone, output dbus_out);
endinterface

// File: rtl/g07_slave_mem_ram.sv
// Single-port DEPTHx64 synchronous RAM, 1-cycle registered read, no reset.
// Latency 1 on read; always accepts (no backpressure).
module g07_slave_ram #(
  parameter int DEPTH = 256,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [IW-1:0] idx,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/g07_slave_mem.sv
// Bus slave responder: writes commit 1 cycle after capture, reads return after READ_LAT cycles.
// Read data is held until the arbiter raises Tdone or drops en; no other backpressure.
module g07_slave_mem
  import g07_pkg::*;
#(
  parameter logic [2:0] SLAVE_ID = 3'd0,
  parameter int          DEPTH    = 256,
  parameter int          READ_LAT = 2
) (
  input  logic           sysClk,
  input  logic           Breset,
  g07_slave_mem_if.slave bus
);

  localparam int IW = $clog2(DEPTH);

  slv_state_t    state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic [63:0]   addr_q, addr_n;
  logic [63:0]   data_q, data_n;
  logic [63:0]   dout_q, dout_n;
  logic          ram_we, ram_re;
  logic [IW-1:0] ram_idx;
  logic [63:0]   ram_rdata;
  logic          req_hit;
  logic          err_q;
  logic          close_req;
  logic          unused_addr;

  assign req_hit     = bus.en && !bus.Tdone && (bus.addr[SEL_HI:SEL_LO] == SLAVE_ID);
  assign close_req   = bus.Tdone || !bus.en;
  assign err_q       = addr_err(addr_q, IW);
  assign unused_addr = ^addr_q[63:60];

  // In IDLE the RAM looks at the live bus address so READ_LAT=1 can read on the capture edge.
  assign ram_idx = (state == IDLE) ? bus.addr[IW+OFS_W-1:OFS_W] : addr_q[IW+OFS_W-1:OFS_W];

  g07_slave_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (sysClk),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (ram_idx),
    .wdata (data_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_q;
    data_n  = data_q;
    dout_n  = dout_q;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    case (state)
      IDLE: begin
        ram_re = (READ_LAT == 1) && req_hit && !bus.addr[WR_BIT];
        if (req_hit) begin
          addr_n = bus.addr;
          data_n = bus.SbusIn;
          if (bus.addr[WR_BIT]) begin
            state_n = WRITE;
          end else begin
            state_n = READ_WAIT;
            cnt_n   = 4'(READ_LAT - 1);
          end
        end
      end
      WRITE: begin
        ram_we  = !err_q;
        state_n = HOLD;
      end
      READ_WAIT: begin
        if (close_req) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt != '0) begin
          // Issue the RAM read one cycle ahead of the load so the latency is exact.
          cnt_n  = cnt - 4'd1;
          ram_re = (cnt == 4'd1);
        end else begin
          dout_n  = err_q ? ERR_DATA : ram_rdata;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (close_req) begin
          state_n = IDLE;
          dout_n  = '0;
        end
      end
      default: begin
        state_n = IDLE;
        dout_n  = '0;
      end
    endcase
  end

  always_ff @(posedge sysClk or negedge Breset) begin
    if (!Breset) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      dout_q <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      addr_q <= addr_n;
      data_q <= data_n;
      dout_q <= dout_n;
    end
  end

  assign bus.dbus_out = dout_q;

endmodule

// File: tb/tb_g07_slave_mem.sv
// Directed bench: four slave instances (READ_LAT 1, 2, 4, 15) share one stimulus bus.
module tb_g07_slave_mem;
  import g07_pkg::*;

  logic        sysClk;
  logic        Breset;
  logic [63:0] addr;
  logic [63:0] SbusIn;
  logic        en;
  logic        Tdone;

  logic [63:0] dout [4];
  logic [1:0]  st   [4];
  int          lat_tab [4] = '{1, 2, 4, 15};

  int n_checks = 0;
  int n_err    = 0;

  localparam logic [63:0] D_ORIG = 64'h0123_4567_89AB_CDEF;

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 15;
    g07_slave_mem_if bus ();
    assign bus.addr   = addr;
    assign bus.SbusIn = SbusIn;
    assign bus.en     = en;
    assign bus.Tdone  = Tdone;
    g07_slave_mem #(.SLAVE_ID(3'd0), .DEPTH(256), .READ_LAT(L)) u_dut (
      .sysClk (sysClk),
      .Breset (Breset),
      .bus    (bus.slave)
    );
    assign dout[g] = bus.dbus_out;
    assign st[g]   = u_dut.state;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sysClk);
    #1;
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d);
    addr = a; SbusIn = d; en = 1'b1; Tdone = 1'b0;
    step();
    check("wr state WRITE", 64'(st[1]), 64'(WRITE));
    step();
    check("wr state HOLD", 64'(st[1]), 64'(HOLD));
    for (int g = 0; g < 4; g++) check($sformatf("wr dout L%0d", lat_tab[g]), dout[g], 64'h0);
    Tdone = 1'b1;
    step();
    check("wr exit IDLE", 64'(st[1]), 64'(IDLE));
    Tdone = 1'b0; en = 1'b0;
  endtask

  // Read, then hold for 15 cycles so every latency variant has delivered; then close.
  task automatic rd(input string nm, input logic [63:0] a, input logic [63:0] exp);
    addr = a; SbusIn = 64'h0; en = 1'b1; Tdone = 1'b0;
    step();
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) step();
      for (int g = 0; g < 4; g++)
        check($sformatf("%s L%0d c%0d", nm, lat_tab[g], c), dout[g],
              (c >= lat_tab[g]) ? exp : 64'h0);
    end
    Tdone = 1'b1;
    step();
    for (int g = 0; g < 4; g++) check($sformatf("%s clear L%0d", nm, lat_tab[g]), dout[g], 64'h0);
    Tdone = 1'b0; en = 1'b0;
  endtask

  initial begin
    Breset = 1'b0; addr = '0; SbusIn = '0; en = 1'b0; Tdone = 1'b0;
    #2;
    for (int g = 0; g < 4; g++) begin
      check($sformatf("reset dout L%0d", lat_tab[g]), dout[g], 64'h0);
      check($sformatf("reset state L%0d", lat_tab[g]), 64'(st[g]), 64'(IDLE));
    end
    step(); step();
    Breset = 1'b1;
    step();

    wr(64'h8000_0000_0000_0040, D_ORIG);
    rd("rd idx8", 64'h0000_0000_0000_0040, D_ORIG);

    // Wrong select (5) write attempt must be ignored.
    addr = 64'hD000_0000_0000_0040; SbusIn = 64'hFFFF_FFFF_FFFF_FFFF; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      for (int g = 0; g < 4; g++) begin
        check($sformatf("wrongsel state L%0d", lat_tab[g]), 64'(st[g]), 64'(IDLE));
        check($sformatf("wrongsel dout L%0d", lat_tab[g]), dout[g], 64'h0);
      end
    end
    en = 1'b0;
    step();
    rd("rd after wrongsel", 64'h0000_0000_0000_0040, D_ORIG);

    rd("rd misaligned", 64'h0000_0000_0000_0043, ERR_DATA);
    wr(64'h8000_0000_0000_0043, 64'h1111_1111_1111_1111);
    rd("rd after mis-wr", 64'h0000_0000_0000_0040, D_ORIG);
    wr(64'h8000_0000_0010_0040, 64'h2222_2222_2222_2222);
    rd("rd after oor-wr", 64'h0000_0000_0000_0040, D_ORIG);
    rd("rd oor", 64'h0000_0000_0010_0040, ERR_DATA);

    // Abort on the cycle after capture.
    addr = 64'h0000_0000_0000_0040; en = 1'b1; Tdone = 1'b0;
    step();
    Tdone = 1'b1;
    step();
    check("abort state L4", 64'(st[2]), 64'(IDLE));
    Tdone = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int g = 0; g < 4; g++) check($sformatf("abort dout L%0d c%0d", lat_tab[g], i), dout[g], 64'h0);
      step();
    end

    // Async reset while holding read data.
    addr = 64'h0000_0000_0000_0040; en = 1'b1;
    step();
    for (int i = 0; i < 15; i++) step();
    for (int g = 0; g < 4; g++) check($sformatf("hold dout L%0d", lat_tab[g]), dout[g], D_ORIG);
    #2;
    Breset = 1'b0; en = 1'b0;
    #1;
    for (int g = 0; g < 4; g++) begin
      check($sformatf("arst dout L%0d", lat_tab[g]), dout[g], 64'h0);
      check($sformatf("arst state L%0d", lat_tab[g]), 64'(st[g]), 64'(IDLE));
    end
    #1;
    Breset = 1'b1;
    step();
    rd("rd after arst", 64'h0000_0000_0000_0040, D_ORIG);

    // Back-to-back: read issued in the first IDLE cycle after the write closes.
    wr(64'h8000_0000_0000_0018, 64'h0000_0000_0000_00AA);
    rd("rd b2b idx3", 64'h0000_0000_0000_0018, 64'h0000_0000_0000_00AA);
    rd("rd b2b idx8", 64'h0000_0000_0000_0040, D_ORIG);

    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
